// File: rtl/mix_column_seq.sv
// mix_column_seq: one AES MixColumns column transform computed by time-sharing
// a single external GF(2^8) multiplier (poly 0x11B), one product per cycle.
//
// Parameter MUL_LAT : 0 = combinational multiplier, 1 = registered multiplier.
//                     Other values are not supported.
// Macro MIXCOL_INV_EN : when defined, i_inv selects InvMixColumns coefficients.
//
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   i_in_valid/o_in_ready, i_in_col[31:0], i_inv   input column handshake
//   o_mul_a[7:0], o_mul_b[7:0], i_mul_p[7:0]       shared multiplier port
//   o_out_valid/i_out_ready, o_out_col[31:0]       result column handshake
module mix_column_seq #(
  parameter int unsigned MUL_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_in_col,
  input  logic        i_inv,
  output logic [7:0]  o_mul_a,
  output logic [7:0]  o_mul_b,
  input  logic [7:0]  i_mul_p,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_out_col
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [31:0]         r_col, w_col_nxt;
  logic [BYTE_W-1:0]   r_acc [4];
  logic [BYTE_W-1:0]   r_mul_a, r_mul_b, w_mul_a_nxt, w_mul_b_nxt;
  logic                r_in_ready, r_out_valid;
  logic                w_in_ready_nxt, w_out_valid_nxt;
  logic                w_hs_in;
  logic                w_acc_en;
  logic [1:0]          w_acc_row;
  logic                w_inv_sel;

  // Byte c of a column, s0 in the top byte.
  function automatic logic [7:0] col_byte(input logic [31:0] col, input logic [1:0] c);
    case (c)
      2'd0:    col_byte = col[31:24];
      2'd1:    col_byte = col[23:16];
      2'd2:    col_byte = col[15:8];
      default: col_byte = col[7:0];
    endcase
  endfunction

`ifdef MIXCOL_INV_EN
  logic r_inv, w_inv_nxt;

  // Circulant coefficient M[row][col] = row0[(col-row) mod 4].
  function automatic logic [7:0] coef(input logic [1:0] row, input logic [1:0] col,
                                      input logic inv);
    logic [1:0] idx;
    idx = col - row;
    case (idx)
      2'd0:    coef = inv ? 8'h0e : 8'h02;
      2'd1:    coef = inv ? 8'h0b : 8'h03;
      2'd2:    coef = inv ? 8'h0d : 8'h01;
      default: coef = inv ? 8'h09 : 8'h01;
    endcase
  endfunction

  assign w_inv_nxt = (r_state == S_IDLE && w_hs_in) ? i_inv : r_inv;
  assign w_inv_sel = w_inv_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_inv <= 1'b0;
    else        r_inv <= w_inv_nxt;
  end
`else
  // Forward-only build: i_inv has no effect.
  logic w_unused_inv;
  assign w_unused_inv = i_inv;
  assign w_inv_sel    = 1'b0;

  function automatic logic [7:0] coef(input logic [1:0] row, input logic [1:0] col,
                                      input logic inv);
    logic [1:0] idx;
    idx = col - row;
    case (idx)
      2'd0:    coef = 8'h02;
      2'd1:    coef = 8'h03;
      default: coef = {7'h00, ~inv};
    endcase
  endfunction
`endif

  assign w_hs_in     = i_in_valid & r_in_ready;
  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_mul_a     = r_mul_a;
  assign o_mul_b     = r_mul_b;
  assign o_out_col   = {r_acc[0], r_acc[1], r_acc[2], r_acc[3]};

  // Which accumulator takes i_mul_p this cycle; lags the operands by MUL_LAT.
  if (MUL_LAT == 1) begin : g_lat1
    logic       r_pvld;
    logic [1:0] r_row_d;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pvld  <= 1'b0;
        r_row_d <= 2'd0;
      end else begin
        r_pvld  <= (r_state == S_RUN);
        r_row_d <= r_cnt[3:2];
      end
    end
    assign w_acc_en  = r_pvld;
    assign w_acc_row = r_row_d;
  end else begin : g_lat0
    assign w_acc_en  = (r_state == S_RUN);
    assign w_acc_row = r_cnt[3:2];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_hs_in) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == 4'd15) w_state_nxt = (MUL_LAT == 1) ? S_FLUSH : S_DONE;
      S_FLUSH: w_state_nxt = S_DONE;
      S_DONE:  if (i_out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath; operands are
  // computed from the next count so they line up with the RUN cycles.
  always_comb begin
    w_cnt_nxt       = r_cnt;
    w_col_nxt       = r_col;
    w_in_ready_nxt  = (w_state_nxt == S_IDLE);
    w_out_valid_nxt = (w_state_nxt == S_DONE);
    w_mul_a_nxt     = 8'h00;
    w_mul_b_nxt     = 8'h00;
    if (r_state == S_IDLE && w_hs_in) begin
      w_col_nxt = i_in_col;
      w_cnt_nxt = 4'd0;
    end else if (r_state == S_RUN) begin
      w_cnt_nxt = r_cnt + 4'd1;
    end
    if (w_state_nxt == S_RUN) begin
      w_mul_a_nxt = coef(w_cnt_nxt[3:2], w_cnt_nxt[1:0], w_inv_sel);
      w_mul_b_nxt = col_byte(w_col_nxt, w_cnt_nxt[1:0]);
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 4'd0;
      r_col       <= 32'd0;
      r_mul_a     <= 8'h00;
      r_mul_b     <= 8'h00;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < 4; i++) r_acc[i] <= 8'h00;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_col       <= w_col_nxt;
      r_mul_a     <= w_mul_a_nxt;
      r_mul_b     <= w_mul_b_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      if (r_state == S_IDLE && w_hs_in) begin
        for (int i = 0; i < 4; i++) r_acc[i] <= 8'h00;
      end else if (w_acc_en) begin
        r_acc[w_acc_row] <= r_acc[w_acc_row] ^ i_mul_p;
      end
    end
  end

endmodule

// File: tb/tb_mix_column_seq.sv
// Bench for mix_column_seq: one instance per multiplier latency, shared stimulus,
// a GF(2^8) reference model and a per-cycle compare process.
module tb_mix_column_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_col = 32'd0;
  logic        inv = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready [2];
  logic [7:0]  mul_a [2];
  logic [7:0]  mul_b [2];
  logic [7:0]  mul_p [2];
  logic        out_valid [2];
  logic [31:0] out_col [2];

  int n_checks = 0;
  int n_pass = 0;

  // Scoreboard state per instance (index = MUL_LAT).
  logic        busy [2] = '{1'b0, 1'b0};
  int          age [2] = '{0, 0};
  logic [31:0] lat_col [2];
  logic        lat_inv [2];
  logic [31:0] exp_col [2];
  logic [31:0] last_out [2];
  int          out_count [2] = '{0, 0};
  logic        after_rst [2] = '{1'b1, 1'b1};
  logic        rnd_ordy = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic eff_inv(input logic v);
`ifdef MIXCOL_INV_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  function automatic logic [7:0] coef_tb(input int r, input int c, input logic iv);
    logic [7:0] row0 [4];
    if (iv) row0 = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else    row0 = '{8'h02, 8'h03, 8'h01, 8'h01};
    return row0[((c - r) % 4 + 4) % 4];
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] col, input int c);
    return col[31 - 8*c -: 8];
  endfunction

  function automatic logic [31:0] mix_model(input logic [31:0] col, input logic iv);
    logic [31:0] res;
    logic [7:0]  acc;
    res = 32'd0;
    for (int r = 0; r < 4; r++) begin
      acc = 8'h00;
      for (int c = 0; c < 4; c++) acc = acc ^ gmul(coef_tb(r, c, iv), byte_of(col, c));
      res[31 - 8*r -: 8] = acc;
    end
    return res;
  endfunction

  task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL dut%0d %s: got %h expected %h at %0t", k, name, act, expv, $time);
  endtask

  mix_column_seq #(.MUL_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(in_ready[0]), .i_in_col(in_col), .i_inv(inv),
    .o_mul_a(mul_a[0]), .o_mul_b(mul_b[0]), .i_mul_p(mul_p[0]),
    .o_out_valid(out_valid[0]), .i_out_ready(out_ready), .o_out_col(out_col[0])
  );

  mix_column_seq #(.MUL_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(in_ready[1]), .i_in_col(in_col), .i_inv(inv),
    .o_mul_a(mul_a[1]), .o_mul_b(mul_b[1]), .i_mul_p(mul_p[1]),
    .o_out_valid(out_valid[1]), .i_out_ready(out_ready), .o_out_col(out_col[1])
  );

  // Multiplier models: combinational and one-cycle registered.
  assign mul_p[0] = gmul(mul_a[0], mul_b[0]);
  always @(posedge clk) mul_p[1] <= gmul(mul_a[1], mul_b[1]);

  // Compare process: sampled mid-cycle, inputs as they will be at the next edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        chk(k, "rst_in_ready", 32'(in_ready[k]), 32'd0);
        chk(k, "rst_out_valid", 32'(out_valid[k]), 32'd0);
        chk(k, "rst_out_col", out_col[k], 32'd0);
        chk(k, "rst_mul_a", 32'(mul_a[k]), 32'd0);
        chk(k, "rst_mul_b", 32'(mul_b[k]), 32'd0);
        busy[k] = 1'b0;
        age[k] = 0;
        out_count[k] = 0;
        after_rst[k] = 1'b1;
      end else begin
        logic [7:0] ea, eb;
        logic       ov;
        int         idx;
        if (busy[k]) age[k]++;
        ea = 8'h00;
        eb = 8'h00;
        if (busy[k] && age[k] >= 1 && age[k] <= 16) begin
          idx = age[k] - 1;
          ea = coef_tb(idx / 4, idx % 4, lat_inv[k]);
          eb = byte_of(lat_col[k], idx % 4);
        end
        chk(k, "mul_a", 32'(mul_a[k]), 32'(ea));
        chk(k, "mul_b", 32'(mul_b[k]), 32'(eb));
        ov = busy[k] && (age[k] >= 17 + k);
        chk(k, "out_valid", 32'(out_valid[k]), 32'(ov));
        if (!after_rst[k]) chk(k, "in_ready", 32'(in_ready[k]), 32'(!busy[k]));
        after_rst[k] = 1'b0;
        if (out_valid[k] && ov) chk(k, "out_col", out_col[k], exp_col[k]);
        if (out_valid[k] && out_ready && busy[k]) begin
          last_out[k] = out_col[k];
          out_count[k]++;
          busy[k] = 1'b0;
        end else if (in_valid && in_ready[k] && !busy[k]) begin
          busy[k] = 1'b1;
          age[k] = 0;
          lat_col[k] = in_col;
          lat_inv[k] = eff_inv(inv);
          exp_col[k] = mix_model(in_col, eff_inv(inv));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ordy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [31:0] col, input logic iv);
    int n;
    n = 0;
    while (!(in_ready[0] && in_ready[1]) && n < 300) begin
      tick();
      n++;
    end
    chk(0, "send_ready_timeout", 32'({in_ready[0], in_ready[1]}), 32'd3);
    in_col = col;
    inv = iv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy[0] || busy[1]) && n < 300) begin
      tick();
      n++;
    end
    chk(0, "idle_timeout", 32'({busy[0], busy[1]}), 32'd0);
  endtask

  initial begin
    // Model pinned by hand-known vectors.
    chk(0, "model_fwd_db", mix_model(32'hdb135345, 1'b0), 32'h8e4da1bc);
    chk(0, "model_fwd_f2", mix_model(32'hf20a225c, 1'b0), 32'h9fdc589d);
    chk(0, "model_01", mix_model(32'h01010101, 1'b0), 32'h01010101);
    chk(0, "model_c6", mix_model(32'hc6c6c6c6, 1'b0), 32'hc6c6c6c6);
    chk(0, "model_00", mix_model(32'h00000000, 1'b0), 32'h00000000);
    chk(0, "model_inv_8e", mix_model(32'h8e4da1bc, 1'b1), 32'hdb135345);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk(0, "ready_after_reset", 32'(in_ready[0]), 32'd1);
    chk(1, "ready_after_reset", 32'(in_ready[1]), 32'd1);

    // Directed vectors.
    send(32'hdb135345, 1'b0);
    wait_idle();
    chk(0, "db135345_out", last_out[0], 32'h8e4da1bc);
    chk(1, "db135345_out", last_out[1], 32'h8e4da1bc);
    send(32'hf20a225c, 1'b0);
    wait_idle();
    chk(1, "f20a225c_out", last_out[1], 32'h9fdc589d);
    send(32'h01010101, 1'b0); wait_idle();
    send(32'hc6c6c6c6, 1'b0); wait_idle();
    send(32'h00000000, 1'b0); wait_idle();
    send(32'h8e4da1bc, 1'b1); wait_idle();
`ifdef MIXCOL_INV_EN
    chk(0, "inv_out", last_out[0], 32'hdb135345);
`else
    chk(0, "inv_ignored_out", last_out[0], mix_model(32'h8e4da1bc, 1'b0));
`endif

    // Backpressure with a held input behind it.
    out_ready = 1'b0;
    send(32'hdb135345, 1'b0);
    for (int n = 0; n < 40 && !(out_valid[0] && out_valid[1]); n++) tick();
    in_col = 32'h01010101;
    inv = 1'b0;
    in_valid = 1'b1;
    repeat (10) tick();
    out_ready = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    chk(0, "held_accept", 32'(busy[0]), 32'd1);
    chk(1, "held_accept", 32'(busy[1]), 32'd1);
    chk(0, "held_col", exp_col[0], 32'h01010101);
    wait_idle();
    chk(0, "held_out", last_out[0], 32'h01010101);

    // Reset in the middle of a run, then one clean column.
    send(32'hdb135345, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(32'hdb135345, 1'b0);
    wait_idle();
    repeat (25) tick();
    chk(0, "post_reset_count", 32'(out_count[0]), 32'd1);
    chk(1, "post_reset_count", 32'(out_count[1]), 32'd1);
    chk(0, "post_reset_out", last_out[0], 32'h8e4da1bc);
    chk(1, "post_reset_out", last_out[1], 32'h8e4da1bc);

    // Random columns with random output backpressure.
    rnd_ordy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send($urandom, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle();
    rnd_ordy = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mix_column_seq.md
# mix_column_seq

Sequencer that computes one AES MixColumns (optionally InvMixColumns) column transform by time-sharing a single external GF(2^8) multiplier. It accepts a 32-bit state column over a valid/ready handshake and drives the multiplier operands for all 16 matrix products, one per cycle. It XOR-accumulates the products into four result bytes and returns the column over a second valid/ready handshake. It sits between the round controller and the shared byte multiplier (reduction polynomial 0x11B) in the round datapath.

## Interface
- MUL_LAT, 0, multiplier latency in cycles: 0 = combinational product same cycle, 1 = product registered one cycle after operands; other values illegal.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input column valid.
- in_ready  out  1  block can accept a column.
- in_col  in  32  column s0..s3, s0 = [31:24], s3 = [7:0].
- inv  in  1  sampled with in_col: 1 = InvMixColumns (only with MIXCOL_INV_EN).
- mul_a  out  8  coefficient operand to multiplier.
- mul_b  out  8  state-byte operand to multiplier.
- mul_p  in  8  product from multiplier.
- out_valid  out  1  result column valid.
- out_ready  in  1  consumer accepts result.
- out_col  out  32  result r0..r3, r0 = [31:24].

## Operation
- FSM states: IDLE, RUN, (FLUSH when MUL_LAT=1), DONE.
- IDLE: in_ready=1. On in_valid&in_ready, register in_col and inv, clear the four accumulators, clear cnt, and go to RUN.
- RUN: 4-bit cnt steps 0..15. row=cnt[3:2], col=cnt[1:0].
  - mul_b = byte col of the latched column.
  - mul_a = coefficient M[row][col], where M is the circulant of row 0 = {02,03,01,01} forward or {0e,0b,0d,09} inverse. M[r][c] = row0[(c-r) mod 4].
- Accumulate: acc[row] ^= mul_p.
  - MUL_LAT=0: the product is taken in the same cycle.
  - MUL_LAT=1: row is delayed one cycle, and the product for cnt=15 is taken in the single FLUSH cycle.
- Coefficient 01 products still go through the multiplier; the cycle count is fixed and independent of data.
- After the last accumulate, go to DONE. out_col={acc0,acc1,acc2,acc3} is held stable and out_valid=1 until out_ready. Then go to IDLE.
- in_ready=0 in RUN, FLUSH and DONE. in_valid there is ignored and not lost; the producer holds it.
- mul_a and mul_b are 8'h00 outside RUN.
- All arithmetic is GF(2^8): addition is 8-bit XOR; no carries, no width growth.

## Timing
- Reset values: in_ready=0 during reset and 1 the first cycle after; out_valid=0, out_col=0, mul_a=0, mul_b=0, cnt=0, state=IDLE.
- Input handshake at edge T. RUN occupies cycles T+1..T+16.
- out_valid rises after edge T+16 (MUL_LAT=0) or T+17 (MUL_LAT=1).
- Output handshake at edge U gives in_ready=1 in cycle U+1. Back-to-back throughput is one column per 18 (19) cycles.
- out_ready high before out_valid has no effect. out_valid never drops without a handshake.
- Reset asserted mid-RUN or mid-DONE aborts at once. All outputs take reset values, and the partial result is discarded with no output.
- in_valid with inv=1 but MIXCOL_INV_EN undefined computes the forward transform.

## Configuration
- MIXCOL_INV_EN defined: the inv input selects the inverse coefficient row {0e,0b,0d,09}, latched at the input handshake.
- MIXCOL_INV_EN undefined: the port is still present but ignored. Only the forward row is built, and the inverse coefficient logic and latched inv flop are removed.

## Test plan
- Forward, MUL_LAT=0: in_col=db135345 -> out_col=8e4da1bc, out_valid 16 cycles after the handshake.
- Forward, MUL_LAT=1: in_col=f20a225c -> out_col=9fdc589d, out_valid 17 cycles after the handshake. Also check mul_a sequence 02,03,01,01,01,02,03,01,...
- Identity/degenerate: 01010101 -> 01010101; c6c6c6c6 -> c6c6c6c6; 00000000 -> 00000000.
- Inverse (MIXCOL_INV_EN): in_col=8e4da1bc, inv=1 -> db135345. Same stimulus without the macro -> forward result of 8e4da1bc.
- Backpressure: hold out_ready=0 for 10 cycles. out_col stays stable and in_ready stays 0. in_valid held with 01010101 is accepted the cycle after the output handshake.
- Reset at cnt=7: rst_n low for 1 cycle -> all outputs 0. The next column db135345 produces exactly one output, 8e4da1bc.
